// File: rtl/display_stream_monitor.sv
// Panel-side checker: deserialises the shift/latch/OE interface and emits one
// {row, bits, on_cycles, shift_cnt} record per displayed pattern on a 1-deep valid/ready slot.
module display_stream_monitor #(
  parameter int segments   = 1,
  parameter int rows       = 8,
  parameter int columns    = 32,
  parameter int countwidth = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3*segments-1:0]           rgb,
  input  logic                            oclk,
  input  logic                            lat,
  input  logic                            oe,
  input  logic [$clog2(rows)-1:0]         row,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(rows)-1:0]         m_row,
  output logic [3*segments*columns-1:0]   m_bits,
  output logic [countwidth-1:0]           m_on_cycles,
  output logic [$clog2(columns+2)-1:0]    m_shift_cnt,
  output logic                            err_overflow,
  output logic                            err_lat_oe,
  output logic                            err_shift,
  input  logic                            err_clear
);

  localparam int rw = $clog2(rows);
  localparam int cw = 3 * segments;
  localparam int bw = cw * columns;
  localparam int sw = $clog2(columns + 2);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_reg;
  logic                  oclk_q_reg;
  logic                  lat_q_reg;
  logic                  lat_armed_reg;
  logic [bw-1:0]         shreg_reg;
  logic [sw-1:0]         shift_cnt_reg;
  logic [bw-1:0]         latched_reg;
  logic [rw-1:0]         lrow_reg;
  logic [sw-1:0]         lshift_reg;
  logic [countwidth-1:0] on_cnt_reg;

  logic                  m_valid_reg;
  logic [rw-1:0]         m_row_reg;
  logic [bw-1:0]         m_bits_reg;
  logic [countwidth-1:0] m_on_cycles_reg;
  logic [sw-1:0]         m_shift_cnt_reg;
  logic                  err_overflow_reg;
  logic                  err_lat_oe_reg;
  logic                  err_shift_reg;

  logic                  oclk_rise;
  logic                  lat_rise;
  logic [bw-1:0]         shreg_next;
  logic [sw-1:0]         shift_cnt_next;
  logic [countwidth-1:0] on_cnt_next;
  logic                  slot_free;
  logic                  emit;

  // A lat rise also requires lat to have been seen low since reset, so
  // releasing reset with lat held high cannot fake a latch.
  always_comb begin
    oclk_rise      = oclk & ~oclk_q_reg;
    lat_rise       = lat & ~lat_q_reg & lat_armed_reg;
    shreg_next     = shreg_reg;
    shift_cnt_next = shift_cnt_reg;
    if (oclk_rise) begin
      shreg_next = {rgb, shreg_reg[bw-1 -: bw-cw]};
      if (shift_cnt_reg != sw'(columns + 1))
        shift_cnt_next = shift_cnt_reg + 1'b1;
    end
    on_cnt_next = on_cnt_reg;
    if (oe && (on_cnt_reg != {countwidth{1'b1}}))
      on_cnt_next = on_cnt_reg + 1'b1;
    slot_free = ~m_valid_reg | m_ready;
    emit      = lat_rise && (state_reg == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      oclk_q_reg       <= 1'b0;
      lat_q_reg        <= 1'b0;
      lat_armed_reg    <= 1'b0;
      shreg_reg        <= '0;
      shift_cnt_reg    <= '0;
      latched_reg      <= '0;
      lrow_reg         <= '0;
      lshift_reg       <= '0;
      on_cnt_reg       <= '0;
      m_valid_reg      <= 1'b0;
      m_row_reg        <= '0;
      m_bits_reg       <= '0;
      m_on_cycles_reg  <= '0;
      m_shift_cnt_reg  <= '0;
      err_overflow_reg <= 1'b0;
      err_lat_oe_reg   <= 1'b0;
      err_shift_reg    <= 1'b0;
    end else begin
      oclk_q_reg    <= oclk;
      lat_q_reg     <= lat;
      lat_armed_reg <= lat_armed_reg | ~lat;
      shreg_reg     <= shreg_next;

      if (lat_rise) begin
        latched_reg   <= shreg_next;
        lrow_reg      <= row;
        lshift_reg    <= shift_cnt_next;
        shift_cnt_reg <= '0;
        on_cnt_reg    <= '0;
        state_reg     <= ACTIVE;
      end else begin
        shift_cnt_reg <= shift_cnt_next;
        if (state_reg == ACTIVE)
          on_cnt_reg <= on_cnt_next;
      end

      // The oe sample of the latch cycle belongs to the outgoing record.
      if (emit && slot_free) begin
        m_valid_reg     <= 1'b1;
        m_row_reg       <= lrow_reg;
        m_bits_reg      <= latched_reg;
        m_on_cycles_reg <= on_cnt_next;
        m_shift_cnt_reg <= lshift_reg;
      end else if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end

      if (err_clear) begin
        err_overflow_reg <= 1'b0;
        err_lat_oe_reg   <= 1'b0;
        err_shift_reg    <= 1'b0;
      end else begin
        if (emit && !slot_free)
          err_overflow_reg <= 1'b1;
        if (lat_rise && oe)
          err_lat_oe_reg <= 1'b1;
        if (lat_rise && (shift_cnt_next != sw'(columns)))
          err_shift_reg <= 1'b1;
      end
    end
  end

  assign m_valid      = m_valid_reg;
  assign m_row        = m_row_reg;
  assign m_bits       = m_bits_reg;
  assign m_on_cycles  = m_on_cycles_reg;
  assign m_shift_cnt  = m_shift_cnt_reg;
  assign err_overflow = err_overflow_reg;
  assign err_lat_oe   = err_lat_oe_reg;
  assign err_shift    = err_shift_reg;

endmodule

// File: tb/tb_display_stream_monitor.sv
// Directed bench for display_stream_monitor (columns=4, segments=1); a second
// instance with countwidth=4 shares the stimulus to exercise on-time saturation.
module tb_display_stream_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rgb = '0;
  logic        oclk = 1'b0;
  logic        lat = 1'b0;
  logic        oe = 1'b0;
  logic [2:0]  row = '0;
  logic        m_ready = 1'b0;
  logic        err_clear = 1'b0;

  logic        m_valid;
  logic [2:0]  m_row;
  logic [11:0] m_bits;
  logic [15:0] m_on_cycles;
  logic [2:0]  m_shift_cnt;
  logic        err_overflow, err_lat_oe, err_shift;

  logic        s_valid;
  logic [2:0]  s_row;
  logic [11:0] s_bits;
  logic [3:0]  s_on_cycles;
  logic [2:0]  s_shift_cnt;
  logic        s_err_overflow, s_err_lat_oe, s_err_shift;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  display_stream_monitor #(.segments(1), .rows(8), .columns(4), .countwidth(16)) dut (
    .clk(clk), .rst(rst), .rgb(rgb), .oclk(oclk), .lat(lat), .oe(oe), .row(row),
    .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row), .m_bits(m_bits),
    .m_on_cycles(m_on_cycles), .m_shift_cnt(m_shift_cnt),
    .err_overflow(err_overflow), .err_lat_oe(err_lat_oe), .err_shift(err_shift),
    .err_clear(err_clear)
  );

  display_stream_monitor #(.segments(1), .rows(8), .columns(4), .countwidth(4)) dut_sat (
    .clk(clk), .rst(rst), .rgb(rgb), .oclk(oclk), .lat(lat), .oe(oe), .row(row),
    .m_valid(s_valid), .m_ready(m_ready), .m_row(s_row), .m_bits(s_bits),
    .m_on_cycles(s_on_cycles), .m_shift_cnt(s_shift_cnt),
    .err_overflow(s_err_overflow), .err_lat_oe(s_err_lat_oe), .err_shift(s_err_shift),
    .err_clear(err_clear)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_col(input logic [2:0] v);
    rgb = v; oclk = 1'b1; tick();
    oclk = 1'b0; tick();
  endtask

  task automatic shift4(input logic [2:0] v);
    for (int i = 0; i < 4; i++) shift_col(v);
  endtask

  task automatic pulse_lat(input logic [2:0] r);
    row = r; lat = 1'b1; tick();
    lat = 1'b0; tick();
  endtask

  task automatic pop();
    m_ready = 1'b1; tick();
    m_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clear = 1'b1; tick();
    err_clear = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset m_valid", m_valid, 0);
    check("reset m_bits", m_bits, 0);
    check("reset errs", {err_overflow, err_lat_oe, err_shift}, 0);

    // 1) first latch captures only; second latch emits the first pattern
    shift_col(3'b001); shift_col(3'b010); shift_col(3'b100); shift_col(3'b111);
    pulse_lat(3'd5);
    check("t1 no record after first lat", m_valid, 0);
    shift4(3'b110);
    pulse_lat(3'd2);
    check("t1 m_valid", m_valid, 1);
    check("t1 m_bits", m_bits, 12'b111_100_010_001);
    check("t1 m_row", m_row, 5);
    check("t1 m_shift_cnt", m_shift_cnt, 4);
    check("t1 m_on_cycles", m_on_cycles, 0);
    check("t1 err_shift", err_shift, 0);
    pop();
    check("t1 pop m_valid", m_valid, 0);

    // 2) 37 oe-high cycles; the 4-bit counter saturates at 15
    oe = 1'b1;
    repeat (37) tick();
    oe = 1'b0;
    shift4(3'b011);
    pulse_lat(3'd3);
    check("t2 m_on_cycles", m_on_cycles, 37);
    check("t2 sat m_on_cycles", s_on_cycles, 15);
    check("t2 m_bits", m_bits, 12'hDB6);
    check("t2 m_row", m_row, 2);
    pop();

    // 3) consumer stalls across three latches: first record held, overflow flagged
    shift4(3'b101);
    pulse_lat(3'd1);
    check("t3 first record valid", m_valid, 1);
    shift4(3'b001);
    pulse_lat(3'd4);
    check("t3 overflow after 2nd lat", err_overflow, 1);
    shift4(3'b010);
    pulse_lat(3'd6);
    check("t3 held m_row", m_row, 3);
    check("t3 held m_bits", m_bits, 12'h6DB);
    check("t3 held m_valid", m_valid, 1);
    pop();
    check("t3 slot freed", m_valid, 0);

    // 4) short row flags err_shift and reports its count in the next record
    clear_errs();
    check("t4 overflow cleared", err_overflow, 0);
    shift_col(3'b111); shift_col(3'b111); shift_col(3'b111);
    pulse_lat(3'd7);
    check("t4 err_shift", err_shift, 1);
    check("t4 prior record shift_cnt", m_shift_cnt, 4);
    pop();
    shift4(3'b000);
    pulse_lat(3'd0);
    check("t4 m_shift_cnt short", m_shift_cnt, 3);
    check("t4 m_row", m_row, 7);
    clear_errs();
    check("t4 err_shift cleared", err_shift, 0);
    pop();

    // 5) lat rise with oe high; then oclk and lat rising together
    oe = 1'b1;
    shift4(3'b100);
    pulse_lat(3'd1);
    oe = 1'b0;
    check("t5 err_lat_oe", err_lat_oe, 1);
    pop();
    clear_errs();
    check("t5 err_lat_oe cleared", err_lat_oe, 0);
    shift_col(3'b000); shift_col(3'b000); shift_col(3'b000);
    rgb = 3'b111; oclk = 1'b1; lat = 1'b1; row = 3'd4; tick();
    oclk = 1'b0; lat = 1'b0; rgb = 3'b000; tick();
    check("t5 coincident counted", err_shift, 0);
    pop();
    shift4(3'b001);
    pulse_lat(3'd0);
    check("t5 coincident m_bits", m_bits, 12'hE00);
    check("t5 coincident m_shift_cnt", m_shift_cnt, 4);
    check("t5 coincident m_row", m_row, 4);
    pop();

    // 6) reset mid-row, held with lat high
    shift_col(3'b101); shift_col(3'b101);
    rst = 1'b1; lat = 1'b1; tick(); tick();
    rst = 1'b0; tick(); tick();
    check("t6 m_valid", m_valid, 0);
    check("t6 m_bits", m_bits, 0);
    check("t6 m_row/cnt", {m_row, m_shift_cnt, m_on_cycles}, 0);
    check("t6 errs", {err_overflow, err_lat_oe, err_shift}, 0);
    lat = 1'b0; tick();
    check("t6 no lat rise from held lat", err_shift, 0);
    shift4(3'b011);
    pulse_lat(3'd2);
    check("t6 first lat no record", m_valid, 0);
    shift4(3'b110);
    pulse_lat(3'd3);
    check("t6 second lat record", m_valid, 1);
    check("t6 record bits", m_bits, 12'h6DB);
    check("t6 record row", m_row, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
